// File: rtl/axi_req_resp_cut.sv
// ----------------------------------------------------------------------------
// axi_req_resp_cut
//
// Register slice on the ariane_axi request/response struct path. It sits
// between the core's AXI master and the struct-to-AXI_BUS master adapter. Each
// of the five channels (AW, W, AR toward the adapter; B, R back to the core)
// is either a 2-slot spill register or a plain wire. The choice is made per
// channel by the CUT_* parameters.
//
// A spill register cuts the valid, ready and payload paths. It still sustains
// one beat per cycle. Channels are fully independent of each other. Payloads
// pass through bit-exact.
//
// Ports
//   clk_i       in   clock, all state on rising edge
//   rst_ni      in   asynchronous active-low reset
//   slv_req_i   in   request from core master (aw/w/ar payload+valid, b/r ready)
//   slv_resp_o  out  response to core master (b/r payload+valid, aw/w/ar ready)
//   mst_req_o   out  request toward the master adapter
//   mst_resp_i  in   response from the master adapter
// ----------------------------------------------------------------------------

package ariane_axi;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [5:0]  atop;
        logic        user;
    } aw_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic        user;
    } w_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [1:0]  resp;
        logic        user;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic        user;
    } ar_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic        user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        logic     b_valid;
        b_chan_t  b;
        logic     r_valid;
        r_chan_t  r;
    } resp_t;

endpackage

// ----------------------------------------------------------------------------
// axi_req_resp_cut_spill
//
// Generic 2-slot spill register for one channel. Slot A drives the output.
// Slot B catches the beat that was already in flight when the output stalled.
// in_ready depends only on the slot-B flag and reset, so no combinational path
// runs from out_ready to in_ready.
//
// Ports
//   clk_i, rst_ni          clock, async active-low reset
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload
// ----------------------------------------------------------------------------
module axi_req_resp_cut_spill #(
    parameter type T = logic [7:0]
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    logic a_full;
    logic b_full;
    T     a_data;
    T     b_data;
    logic in_hs;
    logic out_hs;

    // rst_ni is gated into ready so that nothing is accepted while reset is held.
    assign in_ready  = ~b_full & rst_ni;
    assign in_hs     = in_valid & in_ready;
    assign out_valid = a_full;
    assign out_data  = a_data;
    assign out_hs    = a_full & out_ready;

    // Slot update. A is always filled before B, so "A empty, B full" never
    // occurs. While A is stalled it is left untouched, which keeps the output
    // AXI-stable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_full <= 1'b0;
            b_full <= 1'b0;
            a_data <= '0;
            b_data <= '0;
        end else if (!a_full) begin
            if (in_hs) begin
                a_data <= in_data;
                a_full <= 1'b1;
            end
        end else if (out_hs) begin
            if (b_full) begin
                a_data <= b_data;
                b_full <= 1'b0;
            end else if (in_hs) begin
                a_data <= in_data;
            end else begin
                a_full <= 1'b0;
            end
        end else if (in_hs) begin
            b_data <= in_data;
            b_full <= 1'b1;
        end
    end

endmodule

module axi_req_resp_cut
    import ariane_axi::*;
#(
    parameter bit CUT_AW = 1'b1,
    parameter bit CUT_W  = 1'b1,
    parameter bit CUT_B  = 1'b1,
    parameter bit CUT_AR = 1'b1,
    parameter bit CUT_R  = 1'b1
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  req_t  slv_req_i,
    output resp_t slv_resp_o,
    output req_t  mst_req_o,
    input  resp_t mst_resp_i
);

    aw_chan_t mst_aw;
    logic     mst_aw_valid;
    logic     slv_aw_ready;
    w_chan_t  mst_w;
    logic     mst_w_valid;
    logic     slv_w_ready;
    ar_chan_t mst_ar;
    logic     mst_ar_valid;
    logic     slv_ar_ready;
    b_chan_t  slv_b;
    logic     slv_b_valid;
    logic     mst_b_ready;
    r_chan_t  slv_r;
    logic     slv_r_valid;
    logic     mst_r_ready;

    if (CUT_AW) begin : g_aw_cut
        axi_req_resp_cut_spill #(.T(aw_chan_t)) i_aw (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .in_valid  (slv_req_i.aw_valid),
            .in_ready  (slv_aw_ready),
            .in_data   (slv_req_i.aw),
            .out_valid (mst_aw_valid),
            .out_ready (mst_resp_i.aw_ready),
            .out_data  (mst_aw)
        );
    end else begin : g_aw_wire
        assign mst_aw       = slv_req_i.aw;
        assign mst_aw_valid = slv_req_i.aw_valid;
        assign slv_aw_ready = mst_resp_i.aw_ready;
    end

    if (CUT_W) begin : g_w_cut
        axi_req_resp_cut_spill #(.T(w_chan_t)) i_w (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .in_valid  (slv_req_i.w_valid),
            .in_ready  (slv_w_ready),
            .in_data   (slv_req_i.w),
            .out_valid (mst_w_valid),
            .out_ready (mst_resp_i.w_ready),
            .out_data  (mst_w)
        );
    end else begin : g_w_wire
        assign mst_w       = slv_req_i.w;
        assign mst_w_valid = slv_req_i.w_valid;
        assign slv_w_ready = mst_resp_i.w_ready;
    end

    if (CUT_AR) begin : g_ar_cut
        axi_req_resp_cut_spill #(.T(ar_chan_t)) i_ar (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .in_valid  (slv_req_i.ar_valid),
            .in_ready  (slv_ar_ready),
            .in_data   (slv_req_i.ar),
            .out_valid (mst_ar_valid),
            .out_ready (mst_resp_i.ar_ready),
            .out_data  (mst_ar)
        );
    end else begin : g_ar_wire
        assign mst_ar       = slv_req_i.ar;
        assign mst_ar_valid = slv_req_i.ar_valid;
        assign slv_ar_ready = mst_resp_i.ar_ready;
    end

    // B and R travel in the response direction: input from the adapter, output to the core.
    if (CUT_B) begin : g_b_cut
        axi_req_resp_cut_spill #(.T(b_chan_t)) i_b (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .in_valid  (mst_resp_i.b_valid),
            .in_ready  (mst_b_ready),
            .in_data   (mst_resp_i.b),
            .out_valid (slv_b_valid),
            .out_ready (slv_req_i.b_ready),
            .out_data  (slv_b)
        );
    end else begin : g_b_wire
        assign slv_b       = mst_resp_i.b;
        assign slv_b_valid = mst_resp_i.b_valid;
        assign mst_b_ready = slv_req_i.b_ready;
    end

    if (CUT_R) begin : g_r_cut
        axi_req_resp_cut_spill #(.T(r_chan_t)) i_r (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .in_valid  (mst_resp_i.r_valid),
            .in_ready  (mst_r_ready),
            .in_data   (mst_resp_i.r),
            .out_valid (slv_r_valid),
            .out_ready (slv_req_i.r_ready),
            .out_data  (slv_r)
        );
    end else begin : g_r_wire
        assign slv_r       = mst_resp_i.r;
        assign slv_r_valid = mst_resp_i.r_valid;
        assign mst_r_ready = slv_req_i.r_ready;
    end

    // Reassemble the output structs from the per-channel results so that each
    // struct has exactly one driver.
    always_comb begin
        mst_req_o          = '0;
        mst_req_o.aw       = mst_aw;
        mst_req_o.aw_valid = mst_aw_valid;
        mst_req_o.w        = mst_w;
        mst_req_o.w_valid  = mst_w_valid;
        mst_req_o.b_ready  = mst_b_ready;
        mst_req_o.ar       = mst_ar;
        mst_req_o.ar_valid = mst_ar_valid;
        mst_req_o.r_ready  = mst_r_ready;

        slv_resp_o          = '0;
        slv_resp_o.aw_ready = slv_aw_ready;
        slv_resp_o.ar_ready = slv_ar_ready;
        slv_resp_o.w_ready  = slv_w_ready;
        slv_resp_o.b_valid  = slv_b_valid;
        slv_resp_o.b        = slv_b;
        slv_resp_o.r_valid  = slv_r_valid;
        slv_resp_o.r        = slv_r;
    end

endmodule

// File: tb/tb_axi_req_resp_cut.sv
// ----------------------------------------------------------------------------
// tb_axi_req_resp_cut
//
// Scoreboard bench for axi_req_resp_cut. Drivers push the expected beat of a
// channel into that channel's queue when they offer it. A monitor branch
// watches every output handshake on the falling edge. For each handshake it
// pops the queue and compares the beat. It also checks that a stalled output
// holds both valid and payload.
//
// A second instance with CUT_AR=0 covers the combinational AR path.
// ----------------------------------------------------------------------------
module tb_axi_req_resp_cut;
    import ariane_axi::*;

    logic  clk = 1'b0;
    logic  rst_n;
    req_t  slv_req;
    resp_t slv_resp;
    req_t  mst_req;
    resp_t mst_resp;
    req_t  pt_req;
    resp_t pt_slv_resp;
    req_t  pt_mst_req;
    resp_t pt_resp;

    int vec_count = 0;
    int miss_count = 0;
    int drivers_done;

    aw_chan_t exp_aw[$];
    w_chan_t  exp_w[$];
    ar_chan_t exp_ar[$];
    b_chan_t  exp_b[$];
    r_chan_t  exp_r[$];

    always #5 clk = ~clk;

    axi_req_resp_cut dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .slv_req_i  (slv_req),
        .slv_resp_o (slv_resp),
        .mst_req_o  (mst_req),
        .mst_resp_i (mst_resp)
    );

    axi_req_resp_cut #(.CUT_AR(1'b0)) dut_pt (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .slv_req_i  (pt_req),
        .slv_resp_o (pt_slv_resp),
        .mst_req_o  (pt_mst_req),
        .mst_resp_i (pt_resp)
    );

    // Compare one value and record the outcome.
    task automatic check_output(input string name, input logic [127:0] actual,
                                input logic [127:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic report_timeout(input string name);
        vec_count++;
        miss_count++;
        $display("[TB] FAIL %s: got timeout, expected handshake", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic aw_chan_t mk_aw(input logic [3:0] id, input logic [63:0] addr,
                                       input logic [7:0] len);
        aw_chan_t a;
        a        = '0;
        a.id     = id;
        a.addr   = addr;
        a.len    = len;
        a.size   = 3'd3;
        a.burst  = 2'b01;
        a.cache  = 4'h2;
        a.prot   = 3'b010;
        a.qos    = 4'h5;
        a.region = id ^ 4'hF;
        a.atop   = {2'b10, id};
        a.user   = len[0];
        return a;
    endfunction

    function automatic ar_chan_t mk_ar(input logic [3:0] id, input logic [63:0] addr);
        ar_chan_t a;
        a        = '0;
        a.id     = id;
        a.addr   = addr;
        a.size   = 3'd3;
        a.burst  = 2'b01;
        a.region = 4'h3;
        a.qos    = 4'h1;
        return a;
    endfunction

    function automatic w_chan_t mk_w(input int i, input logic last);
        w_chan_t w;
        w      = '0;
        w.data = {32'hC0DE_0000, 32'(i)};
        w.strb = 8'hFF ^ 8'(i);
        w.last = last;
        return w;
    endfunction

    function automatic r_chan_t mk_r(input int i);
        r_chan_t r;
        r      = '0;
        r.id   = 4'd7;
        r.data = {32'hBEEF_0000, 32'(i)};
        r.last = (i == 15);
        return r;
    endfunction

    function automatic string chan_name(input int ch);
        case (ch)
            0:       return "aw";
            1:       return "w";
            2:       return "ar";
            3:       return "b";
            default: return "r";
        endcase
    endfunction

    task automatic sb_pop(input int ch, output logic [119:0] e, output bit ok);
        ok = 1'b0;
        e  = '0;
        case (ch)
            0: if (exp_aw.size() > 0) begin e = 120'(exp_aw.pop_front()); ok = 1'b1; end
            1: if (exp_w.size() > 0)  begin e = 120'(exp_w.pop_front());  ok = 1'b1; end
            2: if (exp_ar.size() > 0) begin e = 120'(exp_ar.pop_front()); ok = 1'b1; end
            3: if (exp_b.size() > 0)  begin e = 120'(exp_b.pop_front());  ok = 1'b1; end
            default: if (exp_r.size() > 0) begin e = 120'(exp_r.pop_front()); ok = 1'b1; end
        endcase
    endtask

    // Offer one beat upstream. Hold valid until the handshake completes.
    task automatic send_aw(input aw_chan_t a);
        int   n = 0;
        logic hs;
        slv_req.aw = a;
        slv_req.aw_valid = 1'b1;
        exp_aw.push_back(a);
        forever begin
            hs = slv_resp.aw_ready;
            step();
            if (hs) break;
            n++;
            if (n > 200) begin report_timeout("aw_send"); break; end
        end
        slv_req.aw_valid = 1'b0;
    endtask

    task automatic send_w(input w_chan_t w);
        int   n = 0;
        logic hs;
        slv_req.w = w;
        slv_req.w_valid = 1'b1;
        exp_w.push_back(w);
        forever begin
            hs = slv_resp.w_ready;
            step();
            if (hs) break;
            n++;
            if (n > 200) begin report_timeout("w_send"); break; end
        end
        slv_req.w_valid = 1'b0;
    endtask

    task automatic send_ar(input ar_chan_t a);
        int   n = 0;
        logic hs;
        slv_req.ar = a;
        slv_req.ar_valid = 1'b1;
        exp_ar.push_back(a);
        forever begin
            hs = slv_resp.ar_ready;
            step();
            if (hs) break;
            n++;
            if (n > 200) begin report_timeout("ar_send"); break; end
        end
        slv_req.ar_valid = 1'b0;
    endtask

    task automatic send_b(input b_chan_t b);
        int   n = 0;
        logic hs;
        mst_resp.b = b;
        mst_resp.b_valid = 1'b1;
        exp_b.push_back(b);
        forever begin
            hs = mst_req.b_ready;
            step();
            if (hs) break;
            n++;
            if (n > 200) begin report_timeout("b_send"); break; end
        end
        mst_resp.b_valid = 1'b0;
    endtask

    // Output monitor. On every falling edge out of reset it pops and compares
    // each handshaking channel. A channel that was stalled at the previous
    // falling edge must still show the same valid and payload.
    task automatic monitor_loop();
        logic [127:0] prev_word [5];
        bit           stall_prev [5];
        logic         cur_v [5];
        logic         cur_r [5];
        logic [119:0] cur_pl [5];
        logic [127:0] word;
        logic [119:0] e;
        bit           ok;
        for (int ch = 0; ch < 5; ch++) stall_prev[ch] = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int ch = 0; ch < 5; ch++) stall_prev[ch] = 1'b0;
                continue;
            end
            cur_v[0] = mst_req.aw_valid;  cur_r[0] = mst_resp.aw_ready; cur_pl[0] = 120'(mst_req.aw);
            cur_v[1] = mst_req.w_valid;   cur_r[1] = mst_resp.w_ready;  cur_pl[1] = 120'(mst_req.w);
            cur_v[2] = mst_req.ar_valid;  cur_r[2] = mst_resp.ar_ready; cur_pl[2] = 120'(mst_req.ar);
            cur_v[3] = slv_resp.b_valid;  cur_r[3] = slv_req.b_ready;   cur_pl[3] = 120'(slv_resp.b);
            cur_v[4] = slv_resp.r_valid;  cur_r[4] = slv_req.r_ready;   cur_pl[4] = 120'(slv_resp.r);
            for (int ch = 0; ch < 5; ch++) begin
                word = {cur_v[ch], 7'd0, cur_pl[ch]};
                if (stall_prev[ch])
                    check_output({chan_name(ch), "_hold"}, word, prev_word[ch]);
                if (cur_v[ch] && cur_r[ch]) begin
                    sb_pop(ch, e, ok);
                    if (!ok) begin
                        vec_count++;
                        miss_count++;
                        $display("[TB] FAIL %s_extra: got beat %h, expected no beat",
                                 chan_name(ch), cur_pl[ch]);
                    end else begin
                        check_output({chan_name(ch), "_beat"}, 128'(cur_pl[ch]), 128'(e));
                    end
                end
                stall_prev[ch] = cur_v[ch] && !cur_r[ch];
                prev_word[ch]  = word;
            end
        end
    endtask

    // Main sequence
    task automatic apply_stimulus();
        aw_chan_t a;
        b_chan_t  b;
        int       sent;
        int       cyc;
        logic     hs;

        // Reset state
        rst_n    = 1'b0;
        slv_req  = '0;
        mst_resp = '0;
        pt_req   = '0;
        pt_resp  = '0;
        drivers_done = 0;
        mst_resp.aw_ready = 1'b1;
        mst_resp.w_ready  = 1'b1;
        mst_resp.ar_ready = 1'b1;
        slv_req.b_ready   = 1'b1;
        slv_req.r_ready   = 1'b1;
        #12;
        check_output("reset_ready", 128'({slv_resp.aw_ready, slv_resp.w_ready, slv_resp.ar_ready,
                                           mst_req.b_ready, mst_req.r_ready}), 128'(0));
        check_output("reset_valid", 128'({mst_req.aw_valid, mst_req.w_valid, mst_req.ar_valid,
                                           slv_resp.b_valid, slv_resp.r_valid}), 128'(0));
        check_output("reset_aw_payload", 128'(mst_req.aw), 128'(0));
        check_output("reset_r_payload", 128'(slv_resp.r), 128'(0));
        step();
        rst_n = 1'b1;
        #1;
        check_output("release_ready", 128'({slv_resp.aw_ready, slv_resp.w_ready, slv_resp.ar_ready,
                                             mst_req.b_ready, mst_req.r_ready}), 128'(5'h1F));
        step();

        // Write: AW with 1-cycle latency, 4 back-to-back W beats, then B
        a = mk_aw(4'd3, 64'h0000_0000_8000_0000, 8'd3);
        send_aw(a);
        check_output("aw_latency", 128'({mst_req.aw_valid, mst_req.aw}), 128'({1'b1, a}));
        for (int i = 0; i < 4; i++) begin
            send_w(mk_w(i, i == 3));
            check_output("w_stream", 128'({mst_req.w_valid, mst_req.w}), 128'({1'b1, mk_w(i, i == 3)}));
        end
        b = '{id: 4'd3, resp: 2'b00, user: 1'b0};
        send_b(b);
        check_output("b_latency", 128'({slv_resp.b_valid, slv_resp.b}), 128'({1'b1, b}));
        repeat (3) step();

        // Backpressure: capacity of two, then released in order without a gap
        mst_resp.aw_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check_output("aw_ready_free", 128'(slv_resp.aw_ready), 128'(1));
            send_aw(mk_aw(4'(k), 64'(k) << 8, 8'd0));
        end
        slv_req.aw = mk_aw(4'd2, 64'h200, 8'd0);
        slv_req.aw_valid = 1'b1;
        check_output("aw_ready_full", 128'(slv_resp.aw_ready), 128'(0));
        step();
        check_output("aw_ready_full2", 128'(slv_resp.aw_ready), 128'(0));
        exp_aw.push_back(mk_aw(4'd2, 64'h200, 8'd0));
        mst_resp.aw_ready = 1'b1;
        check_output("aw_rel0", 128'({mst_req.aw_valid, mst_req.aw}),
                     128'({1'b1, mk_aw(4'd0, 64'h0, 8'd0)}));
        step();
        check_output("aw_rel1", 128'({mst_req.aw_valid, mst_req.aw}),
                     128'({1'b1, mk_aw(4'd1, 64'h100, 8'd0)}));
        check_output("aw_ready_back", 128'(slv_resp.aw_ready), 128'(1));
        step();
        slv_req.aw_valid = 1'b0;
        check_output("aw_rel2", 128'({mst_req.aw_valid, mst_req.aw}),
                     128'({1'b1, mk_aw(4'd2, 64'h200, 8'd0)}));
        step();
        check_output("aw_idle", 128'(mst_req.aw_valid), 128'(0));

        // Streaming R burst with the downstream ready toggling
        sent = 0;
        cyc  = 0;
        while (sent < 16 && cyc < 200) begin
            slv_req.r_ready  = (cyc % 2 == 0);
            mst_resp.r       = mk_r(sent);
            mst_resp.r_valid = 1'b1;
            hs = mst_req.r_ready;
            if (hs) exp_r.push_back(mk_r(sent));
            step();
            if (hs) sent++;
            cyc++;
        end
        mst_resp.r_valid = 1'b0;
        if (sent < 16) report_timeout("r_stream");
        slv_req.r_ready = 1'b1;
        repeat (4) step();
        check_output("r_drain", 128'(exp_r.size()), 128'(0));

        // Reset with two R beats buffered
        slv_req.r_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check_output("r_fill_ready", 128'(mst_req.r_ready), 128'(1));
            mst_resp.r = mk_r(k + 100);
            mst_resp.r_valid = 1'b1;
            step();
        end
        mst_resp.r_valid = 1'b0;
        check_output("r_full", 128'({slv_resp.r_valid, mst_req.r_ready}), 128'(2'b10));
        rst_n = 1'b0;
        #1;
        check_output("rst_mid_valid", 128'(slv_resp.r_valid), 128'(0));
        check_output("rst_mid_ready", 128'({mst_req.r_ready, slv_resp.aw_ready}), 128'(0));
        step();
        rst_n = 1'b1;
        #1;
        check_output("rst_rel_ready", 128'({mst_req.r_ready, slv_resp.aw_ready}), 128'(2'b11));
        check_output("rst_rel_valid", 128'(slv_resp.r_valid), 128'(0));
        slv_req.r_ready = 1'b1;
        step();

        // Pass-through AR on the CUT_AR=0 instance
        pt_req.ar = mk_ar(4'd5, 64'h1000);
        pt_req.ar_valid = 1'b1;
        pt_resp.ar_ready = 1'b0;
        #1;
        check_output("pt_ar_same_cycle", 128'({pt_mst_req.ar_valid, pt_mst_req.ar}),
                     128'({1'b1, mk_ar(4'd5, 64'h1000)}));
        check_output("pt_ar_ready_lo", 128'(pt_slv_resp.ar_ready), 128'(0));
        pt_resp.ar_ready = 1'b1;
        #1;
        check_output("pt_ar_ready_hi", 128'(pt_slv_resp.ar_ready), 128'(1));
        pt_req.ar_valid = 1'b0;
        #1;
        check_output("pt_ar_drop", 128'(pt_mst_req.ar_valid), 128'(0));
        step();

        // Concurrency: AW, W, AR streams against independent random stalls
        fork
            begin
                for (int i = 0; i < 334; i++) begin
                    if ($urandom_range(0, 3) == 0) step();
                    send_aw(mk_aw(4'(i), 64'(i) << 6, 8'(i)));
                end
                drivers_done++;
            end
            begin
                for (int i = 0; i < 334; i++) begin
                    if ($urandom_range(0, 3) == 0) step();
                    send_w(mk_w(i + 1000, 1'(i % 2)));
                end
                drivers_done++;
            end
            begin
                for (int i = 0; i < 334; i++) begin
                    if ($urandom_range(0, 3) == 0) step();
                    send_ar(mk_ar(4'(i), 64'h4000 + 64'(i)));
                end
                drivers_done++;
            end
            begin
                for (int c = 0; c < 20000 && drivers_done < 3; c++) begin
                    mst_resp.aw_ready = 1'($urandom_range(0, 1));
                    mst_resp.w_ready  = 1'($urandom_range(0, 1));
                    mst_resp.ar_ready = 1'($urandom_range(0, 1));
                    step();
                end
            end
        join
        mst_resp.aw_ready = 1'b1;
        mst_resp.w_ready  = 1'b1;
        mst_resp.ar_ready = 1'b1;
        repeat (6) step();
        check_output("conc_aw_drain", 128'(exp_aw.size()), 128'(0));
        check_output("conc_w_drain", 128'(exp_w.size()), 128'(0));
        check_output("conc_ar_drain", 128'(exp_ar.size()), 128'(0));
    endtask

    initial begin
        fork
            monitor_loop();
            begin
                apply_stimulus();
                $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
                $finish;
            end
            begin
                #2000000;
                vec_count++;
                miss_count++;
                $display("[TB] FAIL watchdog: got no completion, expected end of sequence");
                $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
                $finish;
            end
        join
    end

endmodule
